// File: rtl/fir_pkg.sv
// Shared types for the FIR input feeder.
// Sample type and feeder FSM encoding.
package fir_pkg;

  localparam int FIR_DATA_WIDTH = 24;

  typedef logic [FIR_DATA_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/fir_sample_feeder_if.sv
// Host sample stream into the feeder.
// valid/ready handshake with a two's complement payload.
interface fir_sample_feeder_if #(
  parameter int DATA_WIDTH = fir_pkg::FIR_DATA_WIDTH
);

  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/fir_sample_feeder_fifo.sv
// Synchronous FIFO buffering host samples.
// Head is read combinationally; count is registered.
module sync_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_wr,
  input  logic [DATA_WIDTH-1:0]         i_wdata,
  input  logic                          i_rd,
  output logic [DATA_WIDTH-1:0]         o_rdata,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  wr_ok;
  logic                  rd_ok;

  assign o_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign o_empty = (count == '0);
  assign o_level = count;
  assign o_rdata = mem[rd_ptr];
  assign wr_ok   = i_wr && !o_full;
  assign rd_ok   = i_rd && !o_empty;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Paces buffered host samples into the FIR at a set rate,
// then sends FLUSH_LEN zeros so the filter tail drains.
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int FLUSH_LEN  = 128,
  parameter int DIV_WIDTH  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  fir_sample_feeder_if.slave          s,
  input  logic                        i_start,
  input  logic [DIV_WIDTH-1:0]        i_rate_div,
  input  logic [LEN_WIDTH-1:0]        i_burst_len,
  output logic                        o_en,
  output logic [DATA_WIDTH-1:0]       o_dout,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_underrun,
  output logic [$clog2(FIFO_DEPTH):0] o_level
);

  localparam int FCW = $clog2(FLUSH_LEN + 1);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_LEN - 1);

  feeder_state_t state_q;
  feeder_state_t state_d;

  logic [DIV_WIDTH-1:0]  div_q;
  logic [DIV_WIDTH-1:0]  rate_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  burst_q;
  logic [FCW-1:0]        flush_q;

  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] head;
  logic                  start_ok;
  logic                  pacing;
  logic                  tick;
  logic                  rd;

  assign start_ok = i_start && (state_q == IDLE);
  assign pacing   = (state_q == RUN) || (state_q == FLUSH);
  assign tick     = pacing && (rate_q == '0);
  assign rd       = tick && (state_q == RUN) && !empty;

  assign s.s_ready = !full;
  assign o_busy    = (state_q != IDLE);
  assign o_done    = (state_q == DONE);

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wr    (s.s_valid),
    .i_wdata (s.s_data),
    .i_rd    (rd),
    .o_rdata (head),
    .o_full  (full),
    .o_empty (empty),
    .o_level (o_level)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok)
          state_d = (i_burst_len == '0) ? FLUSH : RUN;
      end
      RUN: begin
        if (tick && (burst_q == len_q - 1'b1))
          state_d = FLUSH;
      end
      FLUSH: begin
        if (tick && (flush_q == FLUSH_LAST))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      rate_q     <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      flush_q    <= '0;
      o_en       <= 1'b0;
      o_dout     <= '0;
      o_underrun <= 1'b0;
    end else begin
      state_q <= state_d;
      o_en    <= tick;
      o_dout  <= rd ? head : '0;
      if (start_ok) begin
        div_q      <= i_rate_div;
        rate_q     <= i_rate_div;
        len_q      <= i_burst_len;
        burst_q    <= '0;
        flush_q    <= '0;
        o_underrun <= 1'b0;
      end else if (tick) begin
        rate_q <= div_q;
        if (state_q == RUN) begin
          burst_q <= burst_q + 1'b1;
          // An empty FIFO still consumes a burst slot.
          if (empty) o_underrun <= 1'b1;
        end
        if (state_q == FLUSH) flush_q <= flush_q + 1'b1;
      end else if (pacing) begin
        rate_q <= rate_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench for fir_sample_feeder.
// Reference: sample queue plus expected strobe list per burst.
module tb_fir_sample_feeder;
  import fir_pkg::*;

  localparam int DW  = 24;
  localparam int FD  = 16;
  localparam int FL  = 128;
  localparam int DVW = 16;
  localparam int LW  = 16;
  localparam int LVW = $clog2(FD) + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [DVW-1:0] rate_div = '0;
  logic [LW-1:0]  burst_len = '0;
  logic           en;
  logic [DW-1:0]  dout;
  logic           busy;
  logic           done;
  logic           underrun;
  logic [LVW-1:0] level;

  fir_sample_feeder_if #(.DATA_WIDTH(DW)) sif ();

  fir_sample_feeder #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD),
    .FLUSH_LEN  (FL),
    .DIV_WIDTH  (DVW),
    .LEN_WIDTH  (LW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .s           (sif.slave),
    .i_start     (start),
    .i_rate_div  (rate_div),
    .i_burst_len (burst_len),
    .o_en        (en),
    .o_dout      (dout),
    .o_busy      (busy),
    .o_done      (done),
    .o_underrun  (underrun),
    .o_level     (level)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc_n = 0;
  int model[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit acc;
    acc = sif.s_valid && sif.s_ready;
    @(posedge clk);
    #1;
    cyc_n++;
    if (acc) model.push_back(int'(sif.s_data));
  endtask

  task automatic push(input int v);
    logic [31:0] w;
    w = v;
    sif.s_valid = 1'b1;
    sif.s_data  = w[DW-1:0];
    step();
    sif.s_valid = 1'b0;
  endtask

  task automatic run_burst(input int div, input int len, input string tag);
    int  exp_q[$];
    int  got_d[$];
    int  got_c[$];
    int  done_c[$];
    int  start_c;
    int  budget;
    int  n;
    bit  exp_ur;
    exp_ur = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (model.size() > 0) exp_q.push_back(model.pop_front());
      else begin
        exp_q.push_back(0);
        exp_ur = 1'b1;
      end
    end
    for (int i = 0; i < FL; i++) exp_q.push_back(0);
    rate_div  = DVW'(div);
    burst_len = LW'(len);
    start     = 1'b1;
    start_c   = cyc_n;
    step();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_urclr"}, 32'(underrun), 32'd0);
    budget = (len + FL + 2) * (div + 1) + 20;
    for (int k = 0; k < budget && done_c.size() == 0; k++) begin
      if (en) begin
        got_d.push_back(int'(dout));
        got_c.push_back(cyc_n);
      end else begin
        chk({tag, "_dout_idle"}, 32'(dout), 32'd0);
      end
      if (done) done_c.push_back(cyc_n);
      step();
    end
    chk({tag, "_done_seen"}, 32'(done_c.size()), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_count"}, 32'(got_d.size()), 32'(exp_q.size()));
    n = (got_d.size() < exp_q.size()) ? got_d.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_data"}, 32'(got_d[i]), 32'(exp_q[i]));
    if (got_c.size() > 0) begin
      chk({tag, "_lat"}, 32'(got_c[0] - start_c), 32'(div + 2));
      if (done_c.size() > 0)
        chk({tag, "_done_at"}, 32'(done_c[0]), 32'(got_c[got_c.size()-1]));
    end
    for (int i = 1; i < got_c.size(); i++)
      chk({tag, "_gap"}, 32'(got_c[i] - got_c[i-1]), 32'(div + 1));
    chk({tag, "_ur"}, 32'(underrun), 32'(exp_ur));
    chk({tag, "_lvl"}, 32'(level), 32'(model.size()));
  endtask

  initial begin
    int n;
    int d;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;

    // 1: reset
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    model.delete();
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lvl", 32'(level), 32'd0);
    chk("rst_rdy", 32'(sif.s_ready), 32'd1);
    chk("rst_ur", 32'(underrun), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);

    // 2: pre-filled burst at div=3
    for (int i = 1; i <= 4; i++) push(i);
    chk("t2_lvl", 32'(level), 32'd4);
    run_burst(3, 4, "t2");

    // 3: fill to full, 17th held off, drain back-to-back
    sif.s_valid = 1'b1;
    for (int k = 0; k < 40 && model.size() < FD; k++) begin
      sif.s_data = DW'($urandom);
      step();
    end
    chk("t3_lvl", 32'(level), 32'(FD));
    chk("t3_rdy", 32'(sif.s_ready), 32'd0);
    sif.s_data = DW'($urandom);
    step();
    sif.s_valid = 1'b0;
    chk("t3_hold", 32'(level), 32'(FD));
    chk("t3_model", 32'(model.size()), 32'(FD));
    run_burst(0, FD, "t3");
    chk("t3_rdy2", 32'(sif.s_ready), 32'd1);

    // 4: underrun after a single max-positive sample
    push(32'h7FFFFF);
    run_burst(int'($urandom_range(2, 0)), 3, "t4");

    // 5: flush only; start also clears underrun
    run_burst(int'($urandom_range(1, 0)), 0, "t5");

    // random burst
    n = int'($urandom_range(10, 1));
    for (int i = 0; i < n; i++) push(int'($urandom));
    d = int'($urandom_range(2, 0));
    run_burst(d, int'($urandom_range(12, 0)), "trand");

    // 6: reset mid-RUN
    model.delete();
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) push(int'($urandom));
    rate_div  = DVW'(1);
    burst_len = LW'(8);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && n < 2; k++) begin
      if (en) n++;
      step();
    end
    chk("t6_pre", 32'(n), 32'd2);
    rst = 1'b0;
    step();
    rst = 1'b1;
    model.delete();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_lvl", 32'(level), 32'd0);
    chk("t6_en", 32'(en), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (en || done) n++;
      step();
    end
    chk("t6_quiet", 32'(n), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
